// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode pipeline register: decode field
// positions, the NOP bubble value and the holding-state encoding.
package fd_pkg;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 27;
    localparam int RD_HI     = 26;
    localparam int RD_LO     = 22;
    localparam int RS_HI     = 21;
    localparam int RS_LO     = 17;
    localparam int RT_HI     = 16;
    localparam int RT_LO     = 12;
    localparam int SHAMT_HI  = 11;
    localparam int SHAMT_LO  = 7;
    localparam int ALUOP_HI  = 6;
    localparam int ALUOP_LO  = 2;
    localparam int IMM_HI    = 16;
    localparam int IMM_LO    = 0;
    localparam int T_HI      = 26;
    localparam int T_LO      = 0;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Encoding doubles as the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } fd_state_e;

endpackage

// File: rtl/fd_field_decode.sv
// Pure combinational field slicer for a 32-bit instruction word; shared by
// every pipeline stage that needs the decoded fields.
module fd_field_decode
    import fd_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  shamt,
    output logic [4:0]  aluOp,
    output logic [16:0] imm,
    output logic [26:0] t
);

    assign opcode = inst[OPCODE_HI:OPCODE_LO];
    assign rd     = inst[RD_HI:RD_LO];
    assign rs     = inst[RS_HI:RS_LO];
    assign rt     = inst[RT_HI:RT_LO];
    assign shamt  = inst[SHAMT_HI:SHAMT_LO];
    assign aluOp  = inst[ALUOP_HI:ALUOP_LO];
    assign imm    = inst[IMM_HI:IMM_LO];
    assign t      = inst[T_HI:T_LO];

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch->decode pipeline register with optional two-entry skid buffer.
// Handshake: a side transfers on a rising edge iff its valid and ready are both high.
module fd_pipe_reg
    import fd_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 12,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [4:0]        opcode,
    output logic [4:0]        rd,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        shamt,
    output logic [4:0]        aluOp,
    output logic [16:0]       imm,
    output logic [26:0]       t,
    output fd_state_e         state
);

    localparam int ENTRY_W = INST_W + PC_W;

    fd_state_e          state_q;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] skid_q;
    logic               ready_q;
    logic               in_tx;
    logic               out_tx;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? ready_q : (!out_valid || out_ready);
    assign in_tx     = in_valid && in_ready;
    assign out_tx    = out_valid && out_ready;
    assign state     = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else if (flush) begin
            // An out-transfer this cycle has already been consumed by decode.
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_tx) begin
                        head_q  <= {inst_in, pc_in};
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_tx && out_tx) begin
                        head_q <= {inst_in, pc_in};
                    end else if (in_tx) begin
                        // Only reachable with SKID=1: in_ready was still high.
                        skid_q  <= {inst_in, pc_in};
                        state_q <= ST_SKID;
                        ready_q <= 1'b0;
                    end else if (out_tx) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_tx) begin
                        head_q  <= skid_q;
                        state_q <= ST_FULL;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Bubble reads as NOP whenever nothing is presented.
    assign inst_out = out_valid ? head_q[ENTRY_W-1:PC_W] : INST_W'(NOP_INST);
    assign pc_out   = out_valid ? head_q[PC_W-1:0] : '0;

    fd_field_decode u_decode (
        .inst   (inst_out[31:0]),
        .opcode (opcode),
        .rd     (rd),
        .rs     (rs),
        .rt     (rt),
        .shamt  (shamt),
        .aluOp  (aluOp),
        .imm    (imm),
        .t      (t)
    );

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Bench for fd_pipe_reg: one SKID=1 and one SKID=0 instance, each compared
// against a queue model of the held entries.
module tb_fd_pipe_reg;
    import fd_pkg::*;

    localparam int IW = 32;
    localparam int PW = 12;
    localparam int EW = IW + PW;
    localparam int OW = 120;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [IW-1:0] inst_in1, inst_out1;
    logic [PW-1:0] pc_in1, pc_out1;
    logic [4:0]    opcode1, rd1, rs1, rt1, shamt1, alu_op1;
    logic [16:0]   imm1;
    logic [26:0]   t1;
    fd_state_e     state1;

    logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [IW-1:0] inst_in0, inst_out0;
    logic [PW-1:0] pc_in0, pc_out0;
    logic [4:0]    opcode0, rd0, rs0, rt0, shamt0, alu_op0;
    logic [16:0]   imm0;
    logic [26:0]   t0;
    fd_state_e     state0;

    fd_pipe_reg #(.INST_W(IW), .PC_W(PW), .SKID(1)) u_dut1 (
        .clock(clock), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .inst_in(inst_in1), .pc_in(pc_in1),
        .out_valid(out_valid1), .out_ready(out_ready1), .inst_out(inst_out1), .pc_out(pc_out1),
        .opcode(opcode1), .rd(rd1), .rs(rs1), .rt(rt1), .shamt(shamt1), .aluOp(alu_op1),
        .imm(imm1), .t(t1), .state(state1)
    );

    fd_pipe_reg #(.INST_W(IW), .PC_W(PW), .SKID(0)) u_dut0 (
        .clock(clock), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .inst_in(inst_in0), .pc_in(pc_in0),
        .out_valid(out_valid0), .out_ready(out_ready0), .inst_out(inst_out0), .pc_out(pc_out0),
        .opcode(opcode0), .rd(rd0), .rs(rs0), .rt(rt0), .shamt(shamt0), .aluOp(alu_op0),
        .imm(imm0), .t(t0), .state(state0)
    );

    logic [OW-1:0] obs1, obs0;
    assign obs1 = {out_valid1, in_ready1, inst_out1, pc_out1, opcode1, rd1, rs1, rt1,
                   shamt1, alu_op1, imm1, t1};
    assign obs0 = {out_valid0, in_ready0, inst_out0, pc_out0, opcode0, rd0, rs0, rt0,
                   shamt0, alu_op0, imm0, t0};

    // Expected queues: entry {inst, pc} in acceptance order, head at index 0.
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q0[$];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [OW-1:0] exp_obs(input logic vld, input logic rdy,
                                              input logic [EW-1:0] e);
        logic [31:0] i;
        logic [11:0] p;
        i = vld ? e[EW-1:PW] : 32'd0;
        p = vld ? e[PW-1:0] : 12'd0;
        return {vld, rdy, i, p, 5'(i >> 27), 5'(i >> 22), 5'(i >> 17), 5'(i >> 12),
                5'(i >> 7), 5'(i >> 2), 17'(i), 27'(i)};
    endfunction

    function automatic logic [OW-1:0] exp1();
        return exp_obs(exp_q1.size() > 0, exp_q1.size() < 2,
                       (exp_q1.size() > 0) ? exp_q1[0] : '0);
    endfunction

    function automatic logic [OW-1:0] exp0();
        return exp_obs(exp_q0.size() > 0, (exp_q0.size() == 0) || out_ready0,
                       (exp_q0.size() > 0) ? exp_q0[0] : '0);
    endfunction

    function automatic fd_state_e exp_state(input int n);
        if (n == 0) return ST_EMPTY;
        if (n == 1) return ST_FULL;
        return ST_SKID;
    endfunction

    // Advance one clock and apply the handshake rules to both models.
    task automatic tick();
        bit in1, out1, in0, out0;
        in1  = in_valid1 && (exp_q1.size() < 2);
        out1 = out_ready1 && (exp_q1.size() > 0);
        in0  = in_valid0 && ((exp_q0.size() == 0) || out_ready0);
        out0 = out_ready0 && (exp_q0.size() > 0);
        @(posedge clock);
        if (reset) begin
            exp_q1.delete();
            exp_q0.delete();
        end else begin
            if (out1) void'(exp_q1.pop_front());
            if (flush1) exp_q1.delete();
            else if (in1) exp_q1.push_back({inst_in1, pc_in1});
            if (out0) void'(exp_q0.pop_front());
            if (flush0) exp_q0.delete();
            else if (in0) exp_q0.push_back({inst_in0, pc_in0});
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (obs1 !== exp_obs(1'b0, 1'b1, '0)) begin
            n_miss++;
            $display("FAIL reset_outputs_skid1 got %h want %h", obs1, exp_obs(1'b0, 1'b1, '0));
        end
        n_vec++;
        if (obs0 !== exp_obs(1'b0, 1'b1, '0)) begin
            n_miss++;
            $display("FAIL reset_outputs_skid0 got %h want %h", obs0, exp_obs(1'b0, 1'b1, '0));
        end
        n_vec++;
        if (state1 !== ST_EMPTY || state0 !== ST_EMPTY) begin
            n_miss++;
            $display("FAIL reset_state got %0d/%0d want 0/0", state1, state0);
        end
    endtask

    task automatic test_decode();
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        inst_in1   = 32'h0884_6000;
        pc_in1     = 12'h005;
        tick();
        in_valid1 = 1'b0;
        #1;
        n_vec++;
        if (out_valid1 !== 1'b1) begin
            n_miss++;
            $display("FAIL decode_valid got %b want 1", out_valid1);
        end
        n_vec++;
        if ({opcode1, rd1, rs1, rt1} !== {5'd1, 5'd2, 5'd2, 5'd6}) begin
            n_miss++;
            $display("FAIL decode_fields got %0d,%0d,%0d,%0d want 1,2,2,6", opcode1, rd1, rs1, rt1);
        end
        n_vec++;
        if (pc_out1 !== 12'h005 || inst_out1 !== 32'h0884_6000) begin
            n_miss++;
            $display("FAIL decode_data got %h/%h want 08846000/005", inst_out1, pc_out1);
        end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        #1;
        n_vec++;
        if (out_valid1 !== 1'b0 || inst_out1 !== 32'd0) begin
            n_miss++;
            $display("FAIL decode_drain got %b/%h want 0/0", out_valid1, inst_out1);
        end
    endtask

    task automatic test_skid_order();
        logic [EW-1:0] a, b, c;
        a = {$urandom(), 12'($urandom())};
        b = {$urandom(), 12'($urandom())};
        c = {$urandom(), 12'($urandom())};
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        {inst_in1, pc_in1} = a;
        #1;
        n_vec++;
        if (in_ready1 !== 1'b1) begin
            n_miss++;
            $display("FAIL skid_ready_a got %b want 1", in_ready1);
        end
        tick();
        {inst_in1, pc_in1} = b;
        #1;
        n_vec++;
        if (in_ready1 !== 1'b1) begin
            n_miss++;
            $display("FAIL skid_ready_b got %b want 1", in_ready1);
        end
        tick();
        {inst_in1, pc_in1} = c;
        #1;
        n_vec++;
        if (in_ready1 !== 1'b0 || state1 !== ST_SKID) begin
            n_miss++;
            $display("FAIL skid_full got ready=%b state=%0d want 0/2", in_ready1, state1);
        end
        tick();
        #1;
        n_vec++;
        if (in_ready1 !== 1'b0 || {inst_out1, pc_out1} !== a) begin
            n_miss++;
            $display("FAIL skid_hold got ready=%b head=%h want 0/%h", in_ready1, {inst_out1, pc_out1}, a);
        end
        out_ready1 = 1'b1;
        #1;
        n_vec++;
        if ({out_valid1, inst_out1, pc_out1} !== {1'b1, a}) begin
            n_miss++;
            $display("FAIL skid_out_a got %h want %h", {inst_out1, pc_out1}, a);
        end
        tick();
        #1;
        n_vec++;
        if ({out_valid1, inst_out1, pc_out1} !== {1'b1, b}) begin
            n_miss++;
            $display("FAIL skid_out_b got %h want %h", {inst_out1, pc_out1}, b);
        end
        tick();
        in_valid1 = 1'b0;
        #1;
        n_vec++;
        if ({out_valid1, inst_out1, pc_out1} !== {1'b1, c}) begin
            n_miss++;
            $display("FAIL skid_out_c got %h want %h", {inst_out1, pc_out1}, c);
        end
        tick();
        out_ready1 = 1'b0;
        #1;
        n_vec++;
        if (out_valid1 !== 1'b0) begin
            n_miss++;
            $display("FAIL skid_empty got %b want 0", out_valid1);
        end
    endtask

    task automatic test_back_to_back();
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        {inst_in1, pc_in1} = {$urandom(), 12'($urandom())};
        tick();
        for (int k = 0; k < 10; k++) begin
            out_ready1 = 1'b1;
            {inst_in1, pc_in1} = {$urandom(), 12'($urandom())};
            #1;
            n_vec++;
            if (out_valid1 !== 1'b1 || state1 !== ST_FULL || obs1 !== exp1()) begin
                n_miss++;
                $display("FAIL stream_%0d got %h state=%0d want %h state=1", k, obs1, state1, exp1());
            end
            tick();
        end
        in_valid1 = 1'b0;
        tick();
        out_ready1 = 1'b0;
        #1;
        n_vec++;
        if (out_valid1 !== 1'b0 || state1 !== ST_EMPTY) begin
            n_miss++;
            $display("FAIL stream_drain got %b state=%0d want 0/0", out_valid1, state1);
        end
    endtask

    task automatic fill_two();
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            {inst_in1, pc_in1} = {$urandom(), 12'($urandom())};
            tick();
        end
    endtask

    task automatic test_flush_skid();
        fill_two();
        {inst_in1, pc_in1} = {$urandom() | 32'h1, 12'($urandom())};
        flush1 = 1'b1;
        #1;
        n_vec++;
        if (state1 !== ST_SKID) begin
            n_miss++;
            $display("FAIL flush_pre_state got %0d want 2", state1);
        end
        tick();
        flush1    = 1'b0;
        in_valid1 = 1'b0;
        #1;
        n_vec++;
        if (obs1 !== exp_obs(1'b0, 1'b1, '0) || state1 !== ST_EMPTY) begin
            n_miss++;
            $display("FAIL flush_outputs got %h state=%0d want %h state=0", obs1, state1, exp_obs(1'b0, 1'b1, '0));
        end
        out_ready1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            n_vec++;
            if (out_valid1 !== 1'b0) begin
                n_miss++;
                $display("FAIL flush_leak_%0d got %b want 0", k, out_valid1);
            end
        end
        out_ready1 = 1'b0;
    endtask

    task automatic test_reset_flush();
        fill_two();
        reset  = 1'b1;
        flush1 = 1'b1;
        {inst_in1, pc_in1} = {$urandom(), 12'($urandom())};
        tick();
        reset     = 1'b0;
        flush1    = 1'b0;
        in_valid1 = 1'b0;
        #1;
        n_vec++;
        if (obs1 !== exp_obs(1'b0, 1'b1, '0) || state1 !== ST_EMPTY) begin
            n_miss++;
            $display("FAIL reset_flush got %h state=%0d want %h state=0", obs1, state1, exp_obs(1'b0, 1'b1, '0));
        end
    endtask

    task automatic test_random_skid1();
        for (int k = 0; k < 300; k++) begin
            in_valid1  = 1'($urandom_range(0, 1));
            out_ready1 = ($urandom_range(0, 3) != 0);
            flush1     = ($urandom_range(0, 31) == 0);
            {inst_in1, pc_in1} = {$urandom(), 12'($urandom())};
            #1;
            n_vec++;
            if (obs1 !== exp1() || state1 !== exp_state(exp_q1.size())) begin
                n_miss++;
                $display("FAIL rand1_%0d got %h state=%0d want %h state=%0d", k, obs1, state1,
                         exp1(), exp_state(exp_q1.size()));
            end
            tick();
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        flush1     = 1'b0;
        tick();
        tick();
        out_ready1 = 1'b0;
    endtask

    task automatic test_random_skid0();
        for (int k = 0; k < 1000; k++) begin
            in_valid0  = 1'($urandom_range(0, 1));
            out_ready0 = 1'($urandom_range(0, 1));
            flush0     = ($urandom_range(0, 63) == 0);
            {inst_in0, pc_in0} = {$urandom(), 12'($urandom())};
            #1;
            n_vec++;
            if (obs0 !== exp0() || state0 !== exp_state(exp_q0.size())) begin
                n_miss++;
                $display("FAIL rand0_%0d got %h state=%0d want %h state=%0d", k, obs0, state0,
                         exp0(), exp_state(exp_q0.size()));
            end
            tick();
        end
        in_valid0 = 1'b0;
        flush0    = 1'b0;
    endtask

    initial begin
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; inst_in1 = '0; pc_in1 = '0;
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; inst_in0 = '0; pc_in0 = '0;
        @(negedge clock);
        test_reset();
        test_decode();
        test_skid_order();
        test_back_to_back();
        test_flush_skid();
        test_reset_flush();
        test_random_skid1();
        test_random_skid0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fd_pipe_reg.md
FD_PIPE_REG -- requirements
Module: fd_pipe_reg

Interface
REQ-001 The block SHALL have parameter INST_W, default 32, meaning instruction width (min 32; decode fields use bits [31:0]).
REQ-002 The block SHALL have parameter PC_W, default 12, meaning sequential-next-PC width.
REQ-003 The block SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered in_ready, 0 = single entry with combinational in_ready.
REQ-004 The block SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port flush  input  1  discard all held entries (branch/jump redirect).
REQ-007 The block SHALL have port in_valid  input  1  fetch offers inst_in/pc_in.
REQ-008 The block SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 The block SHALL have ports inst_in  input  INST_W  and pc_in  input  PC_W  fetched instruction and its seqNextPc.
REQ-010 The block SHALL have port out_valid  output  1  head entry presented to decode.
REQ-011 The block SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-012 The block SHALL have ports inst_out  output  INST_W  and pc_out  output  PC_W  head entry.
REQ-013 The block SHALL have ports opcode, rd, rs, rt, shamt, aluOp  output  5 each; imm  output  17; t  output  27  decoded from inst_out bits [31:27],[26:22],[21:17],[16:12],[11:7],[6:2],[16:0],[26:0].

Function
REQ-014 Transfer in SHALL occur iff in_valid && in_ready; transfer out SHALL occur iff out_valid && out_ready.
REQ-015 An accepted entry SHALL appear at outputs on the next cycle (latency 1) when the block was empty.
REQ-016 Entries SHALL leave in acceptance order; none dropped or duplicated except by flush/reset.
REQ-017 SKID=1: states EMPTY, FULL, SKID (0/1/2 entries); EMPTY->FULL on in-transfer; FULL->EMPTY on out-transfer without in-transfer; FULL->SKID on in-transfer without out-transfer; FULL stays FULL on simultaneous in/out; SKID->FULL on out-transfer.
REQ-018 SKID=1: in_ready SHALL be a register output, 0 only in state SKID.
REQ-019 SKID=0: in_ready SHALL equal !out_valid || out_ready; simultaneous in/out keeps one entry (replaced).
REQ-020 flush SHALL empty the block on the next edge (state EMPTY, out_valid=0); an in-transfer in the flush cycle SHALL be discarded; an out-transfer in the flush cycle still completes.
REQ-021 While out_valid=0, inst_out, pc_out and all decoded fields SHALL read 0 (NOP bubble).
REQ-022 Decoded fields SHALL be combinational slices of the registered head entry, never of inst_in.
REQ-023 Head data SHALL hold stable while out_valid && !out_ready.

Reset
REQ-024 reset SHALL take priority over flush and all handshakes.
REQ-025 After reset: state EMPTY, out_valid=0, all data outputs 0, in_ready=1 (both SKID settings).
REQ-026 Reset asserted mid-operation SHALL discard all entries at that edge; no entry accepted in the reset cycle.

Structure
REQ-027 Field bit positions, NOP value (0) and the state encoding SHALL live in shared package fd_pkg.
REQ-028 Field slicing SHALL be one combinational sub-module fd_field_decode, reused by later pipeline stages.
REQ-029 Entry storage SHALL be two INST_W+PC_W registers (head, skid) with a state register; no latches.

Verification
REQ-030 Reset then in_valid=1, inst_in=32'h0884_6000, pc_in=12'h005 -> next cycle out_valid=1, opcode=1, rd=2, rs=2, rt=6, pc_out=12'h005.
REQ-031 SKID=1, out_ready=0, offer A,B,C back-to-back -> A,B accepted, in_ready=0 after B, C held off; out_ready=1 -> outputs A then B then C, in order.
REQ-032 FULL state, in_valid=1 and out_ready=1 same cycle for 10 cycles -> one entry per cycle, no bubbles, state stays FULL.
REQ-033 SKID state, assert flush with in_valid=1 -> next cycle out_valid=0, all outputs 0, in_ready=1; flushed input never appears.
REQ-034 Reset and flush asserted together while SKID holds 2 entries -> post-reset values of REQ-025 exactly.
REQ-035 SKID=0, random in_valid/out_ready, 1000 cycles -> scoreboard order intact, in_ready == !out_valid || out_ready every cycle.
